// File: rtl/register_bank_sb.sv
// register_bank_sb: register bank for the 16-bit MIPS pipeline, between decode and execute.
//   - One write port.
//   - Two registered read ports with write-through bypass.
//   - EX/DM/WB forwarding muxes on both operands, plus an immediate select on operand B.
//   - Busy-bit scoreboard that raises a stall while a source register has a write pending.
//
// Ports:
//   clk, rst                  rising-edge clock, asynchronous active-high reset
//   ra, rb, rd_en             read addresses; rd_en=1 captures new data into ar/br, 0 holds them
//   wr_en, rw, wdata          writeback port
//   busy_set, busy_addr       marks busy_addr as having a pending write
//   ans_ex, ans_dm, ans_wb    forwarded results
//   mux_sel_a, mux_sel_b      operand select: 00 register, 01 EX, 10 DM, 11 WB
//   imm_sel, imm              1 = operand b is imm
//   a, b                      operands to the ALU
//   stall                     a source register is busy
module register_bank_sb #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 5,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] rw,
    input  logic [DATA_W-1:0] wdata,
    input  logic              busy_set,
    input  logic [ADDR_W-1:0] busy_addr,
    input  logic [DATA_W-1:0] ans_ex,
    input  logic [DATA_W-1:0] ans_dm,
    input  logic [DATA_W-1:0] ans_wb,
    input  logic [1:0]        mux_sel_a,
    input  logic [1:0]        mux_sel_b,
    input  logic              imm_sel,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic              stall
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DATA_W-1:0] ar_q, ar_d;
    logic [DATA_W-1:0] br_q, br_d;
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [DATA_W-1:0] bi;

    logic wr_ok;
    logic ra_zero, rb_zero;

    assign wr_ok   = wr_en && !(ZERO_REG && (rw == '0));
    assign ra_zero = ZERO_REG && (ra == '0);
    assign rb_zero = ZERO_REG && (rb == '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_ok) begin
            regs_d[rw] = wdata;
        end
    end

    // The read captures wdata when it targets the register being written on
    // the same edge. The hardwired zero register is never bypassed.
    always_comb begin
        ar_d = ar_q;
        br_d = br_q;
        if (rd_en) begin
            if (ra_zero) begin
                ar_d = '0;
            end else if (wr_en && (rw == ra)) begin
                ar_d = wdata;
            end else begin
                ar_d = regs_q[ra];
            end

            if (rb_zero) begin
                br_d = '0;
            end else if (wr_en && (rw == rb)) begin
                br_d = wdata;
            end else begin
                br_d = regs_q[rb];
            end
        end
    end

    // The clear is applied before the set, so a set on the same address wins.
    // The newer instruction owns the register.
    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[rw] = 1'b0;
        end
        if (busy_set && !(ZERO_REG && (busy_addr == '0))) begin
            busy_d[busy_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '{default: '0};
            ar_q   <= '0;
            br_q   <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            ar_q   <= ar_d;
            br_q   <= br_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        a = ar_q;
        case (mux_sel_a)
            2'b00:   a = ar_q;
            2'b01:   a = ans_ex;
            2'b10:   a = ans_dm;
            default: a = ans_wb;
        endcase
    end

    always_comb begin
        bi = br_q;
        case (mux_sel_b)
            2'b00:   bi = br_q;
            2'b01:   bi = ans_ex;
            2'b10:   bi = ans_dm;
            default: bi = ans_wb;
        endcase
    end

    assign b = imm_sel ? imm : bi;

    // Stall uses the registered busy bits. A register being cleared by this
    // cycle's write therefore still stalls for this cycle.
    assign stall = rd_en & (busy_q[ra] | busy_q[rb]);

endmodule

// File: tb/tb_register_bank_sb.sv
module tb_register_bank_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ra, rb, rw, busy_addr;
    logic        rd_en, wr_en, busy_set, imm_sel;
    logic [15:0] wdata, ans_ex, ans_dm, ans_wb, imm, a, b;
    logic [1:0]  mux_sel_a, mux_sel_b;
    logic        stall;

    logic [2:0]  p_ra, p_rb, p_rw, p_busy_addr;
    logic        p_rd_en, p_wr_en, p_busy_set;
    logic [31:0] p_wdata, p_a, p_b;
    logic        p_stall;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    register_bank_sb #(.DATA_W(16), .ADDR_W(5), .ZERO_REG(1'b1)) u_dut (
        .clk(clk), .rst(rst), .ra(ra), .rb(rb), .rd_en(rd_en), .wr_en(wr_en),
        .rw(rw), .wdata(wdata), .busy_set(busy_set), .busy_addr(busy_addr),
        .ans_ex(ans_ex), .ans_dm(ans_dm), .ans_wb(ans_wb),
        .mux_sel_a(mux_sel_a), .mux_sel_b(mux_sel_b), .imm_sel(imm_sel), .imm(imm),
        .a(a), .b(b), .stall(stall)
    );

    register_bank_sb #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(1'b0)) u_dut_p (
        .clk(clk), .rst(rst), .ra(p_ra), .rb(p_rb), .rd_en(p_rd_en), .wr_en(p_wr_en),
        .rw(p_rw), .wdata(p_wdata), .busy_set(p_busy_set), .busy_addr(p_busy_addr),
        .ans_ex(32'h0), .ans_dm(32'h0), .ans_wb(32'h0),
        .mux_sel_a(2'b00), .mux_sel_b(2'b00), .imm_sel(1'b0), .imm(32'h0),
        .a(p_a), .b(p_b), .stall(p_stall)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 0; rd_en = 0; busy_set = 0;
        p_wr_en = 0; p_rd_en = 0; p_busy_set = 0;
    endtask

    initial begin
        rst = 1; idle();
        ra = 0; rb = 0; rw = 0; busy_addr = 0; wdata = 0;
        ans_ex = 16'd1; ans_dm = 16'd2; ans_wb = 16'd3; imm = 0; imm_sel = 0;
        mux_sel_a = 0; mux_sel_b = 0;
        p_ra = 0; p_rb = 0; p_rw = 0; p_busy_addr = 0; p_wdata = 0;
        step(); step();
        check("reset_a", a, 0);
        check("reset_b", b, 0);
        check("reset_stall", stall, 0);
        rst = 0;
        step();

        // 1. reset clears contents, operands and busy bits immediately
        wr_en = 1; rw = 3; wdata = 16'h1234; step();
        wr_en = 0; rd_en = 1; ra = 3; rb = 3; step();
        check("pre_rst_a", a, 16'h1234);
        busy_set = 1; busy_addr = 3; step();
        busy_set = 0; #1;
        check("pre_rst_stall", stall, 1);
        #1 rst = 1;
        #1;
        check("async_rst_a", a, 0);
        check("async_rst_b", b, 0);
        check("async_rst_stall", stall, 0);
        #1 rst = 0;
        step();
        check("post_rst_read3", a, 0);
        wr_en = 1; rw = 0; wdata = 16'hFFFF; ra = 0; step();
        check("zero_no_bypass", a, 0);
        wr_en = 0; step();
        check("zero_read", a, 0);

        // 2. write then read
        rd_en = 0; wr_en = 1; rw = 5; wdata = 16'hA5A5; step();
        wr_en = 0; rd_en = 1; ra = 5; rb = 5; step();
        check("read_a5", a, 16'hA5A5);
        check("read_b5", b, 16'hA5A5);

        // 3. bypass and hold
        rd_en = 0; wr_en = 1; rw = 7; wdata = 16'h1111; step();
        wr_en = 1; rw = 7; wdata = 16'h00FF; rd_en = 1; ra = 7; step();
        check("bypass_a", a, 16'h00FF);
        check("bypass_b_other", b, 16'hA5A5);
        wr_en = 0; rd_en = 0; ra = 2; step();
        check("hold_a", a, 16'h00FF);

        // 4. forwarding muxes and immediate
        mux_sel_a = 2'b00; #1 check("fwd_a00", a, 16'h00FF);
        mux_sel_a = 2'b01; #1 check("fwd_a01", a, 16'd1);
        mux_sel_a = 2'b10; #1 check("fwd_a10", a, 16'd2);
        mux_sel_a = 2'b11; #1 check("fwd_a11", a, 16'd3);
        mux_sel_a = 2'b00;
        mux_sel_b = 2'b01; #1 check("fwd_b01", b, 16'd1);
        mux_sel_b = 2'b10; #1 check("fwd_b10", b, 16'd2);
        mux_sel_b = 2'b11; #1 check("fwd_b11", b, 16'd3);
        imm_sel = 1; imm = 16'h8000;
        for (int i = 0; i < 4; i++) begin
            mux_sel_b = 2'(i);
            #1 check("imm_b", b, 16'h8000);
        end
        imm_sel = 0; mux_sel_b = 2'b00;
        step();

        // 5. scoreboard
        busy_set = 1; busy_addr = 9; step();
        busy_set = 0; rd_en = 1; ra = 9; rb = 1; #1;
        check("busy_stall", stall, 1);
        wr_en = 1; rw = 9; wdata = 16'h0009; #1;
        check("clear_cycle_stall", stall, 1);
        step();
        wr_en = 0; #1;
        check("cleared_stall", stall, 0);
        busy_set = 1; busy_addr = 9; wr_en = 1; rw = 9; step();
        busy_set = 0; wr_en = 0; #1;
        check("set_wins_stall", stall, 1);
        busy_set = 1; busy_addr = 10; wr_en = 1; rw = 9; step();
        busy_set = 0; wr_en = 0; ra = 9; rb = 9; #1;
        check("diff_clear_stall", stall, 0);
        ra = 10; #1;
        check("diff_set_stall", stall, 1);
        rd_en = 0; #1;
        check("no_rd_no_stall", stall, 0);
        busy_set = 1; busy_addr = 0; step();
        busy_set = 0; rd_en = 1; ra = 0; rb = 0; #1;
        check("zero_never_busy", stall, 0);
        idle();
        step();

        // 6. alternate parameters: wide data, ordinary register 0
        p_wr_en = 1; p_rw = 0; p_wdata = 32'hDEADBEEF; step();
        p_wr_en = 0; p_rd_en = 1; p_ra = 0; p_rb = 0; step();
        check("p_read0", p_a, 32'hDEADBEEF);
        check("p_read0_b", p_b, 32'hDEADBEEF);
        p_busy_set = 1; p_busy_addr = 0; step();
        p_busy_set = 0; #1;
        check("p_busy0_stall", p_stall, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/register_bank_sb.md
Name: register_bank_sb

Overview:
- Parametrised next-generation register bank for the 16-bit MIPS pipeline.
- One write port, two registered read ports with write-through bypass, per-operand forwarding muxes (EX/DM/WB) and an immediate select on operand B.
- Adds what the previous bank lacks: asynchronous reset, write enable, read enable (hold), optional hardwired zero register, and a busy-bit scoreboard that raises a stall when a source register has a write pending.
- Sits between decode and execute; a and b feed the ALU.

Parameters:
DATA_W, 16, register and operand width
ADDR_W, 5, register address width; depth = 2**ADDR_W
ZERO_REG, 1, 1 = register 0 always reads 0, ignores writes and is never busy; 0 = register 0 is ordinary

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
ra  input  ADDR_W  source A address
rb  input  ADDR_W  source B address
rd_en  input  1  1 = capture new read data into ar/br; 0 = hold
wr_en  input  1  write enable
rw  input  ADDR_W  write address
wdata  input  DATA_W  write data (writeback result)
busy_set  input  1  mark busy_addr as having a pending write
busy_addr  input  ADDR_W  destination being issued
ans_ex  input  DATA_W  forwarded EX result
ans_dm  input  DATA_W  forwarded DM result
ans_wb  input  DATA_W  forwarded WB result
mux_sel_a  input  2  00 ar, 01 ans_ex, 10 ans_dm, 11 ans_wb
mux_sel_b  input  2  same encoding for B
imm_sel  input  1  1 = b is imm
imm  input  DATA_W  immediate operand
a  output  DATA_W  operand A
b  output  DATA_W  operand B
stall  output  1  source register busy

Behaviour:
- Reset (async, while rst=1): all 2**ADDR_W registers = 0; ar = br = 0; all busy bits = 0. Consequences: a = 0 when mux_sel_a=00; b = 0 when mux_sel_b=00 and imm_sel=0; stall = 0. Reset mid-operation discards pending writes and busy bits immediately, without waiting for a clock edge.
- Write: on the rising edge with wr_en=1, reg[rw] <= wdata. If ZERO_REG=1 and rw=0, the write is dropped.
- Read: on the rising edge with rd_en=1, ar <= reg[ra] and br <= reg[rb]. Latency is one cycle from address to ar/br.
  - Bypass: if wr_en=1 and rw equals ra (or rb) on the same edge, ar (or br) captures wdata, not the old contents.
  - Zero register: if ZERO_REG=1 and the address is 0, capture 0 and never bypass.
  - Hold: with rd_en=0, ar and br keep their values. Writes and scoreboard updates still occur.
- Operand muxes (combinational):
  - a = ar / ans_ex / ans_dm / ans_wb per mux_sel_a.
  - bi = the same selection per mux_sel_b.
  - b = imm if imm_sel=1, else bi.
  - All selections are full width; there is no zero default.
- Scoreboard: one busy bit per register, updated on the rising edge.
  - busy_set=1 sets busy[busy_addr].
  - wr_en=1 clears busy[rw].
  - Set and clear on the same address in the same cycle: set wins, because the newer instruction owns the register.
  - Set and clear on different addresses both take effect.
  - ZERO_REG=1: busy[0] is never set.
- stall (combinational) = rd_en & (busy[ra] | busy[rb]).
  - The write-through rule applies: a register being cleared this cycle by wr_en at rw still counts as busy for that cycle's stall. Bypass data is correct, but stall is kept conservative.
  - The block does not itself gate rd_en on stall; the control unit deasserts rd_en.
- Wrap-around: addresses are ADDR_W bits; there are no out-of-range addresses.

Test Plan:
1. Reset and zero register: assert rst mid-cycle after writing reg[3]=16'h1234 → a, b and stall are 0 immediately. After release, read ra=3 → ar=0. Write rw=0, wdata=16'hFFFF (ZERO_REG=1), read ra=0 → 0.
2. Write then read: write reg[5]=16'hA5A5 at edge N. Read ra=5, rb=5 at edge N+1 → a=b=16'hA5A5 at cycle N+1 with mux_sel=00.
3. Bypass: same edge wr_en=1, rw=7, wdata=16'h00FF with rd_en=1, ra=7; reg[7] was 16'h1111 → ar=16'h00FF. With rd_en=0 on the next edge, ra=2 → ar holds 16'h00FF.
4. Forwarding and immediate: ans_ex=1, ans_dm=2, ans_wb=3. Sweep mux_sel_a 00..11 → a = ar, 1, 2, 3. imm_sel=1, imm=16'h8000 → b=16'h8000 regardless of mux_sel_b.
5. Scoreboard: busy_set, busy_addr=9; next cycle rd_en=1, ra=9 → stall=1. wr_en, rw=9 → stall=1 that cycle, 0 the next. Same-cycle busy_set=9 and wr_en rw=9 → busy[9] stays 1.
6. Parameter sweep: DATA_W=32, ADDR_W=3, ZERO_REG=0 → write reg[0]=32'hDEADBEEF, read back DEADBEEF. busy_set on addr 0 → stall=1 with ra=0.
